// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : valid/ready inter-stage register with 2-entry skid buffer,
//                  flush-to-bubble, delay-slot tracking and cause merging.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [DATA_W-1:0] i_up_data,
  input  logic [CTRL_W-1:0] i_up_ctrl,
  input  logic [31:0]       i_up_pc,
  input  logic [31:0]       i_up_instr,
  input  logic              i_up_is_branch,
  input  logic              i_up_bad_addr,
  input  logic              i_up_dmem_we,
  input  logic [4:0]        i_up_except_cause,
  output logic              o_dn_valid,
  input  logic              i_dn_ready,
  output logic [DATA_W-1:0] o_dn_data,
  output logic [CTRL_W-1:0] o_dn_ctrl,
  output logic [31:0]       o_dn_pc,
  output logic [31:0]       o_dn_instr,
  output logic              o_dn_is_branch,
  output logic              o_dn_in_delay_slot,
  output logic [4:0]        o_dn_except_cause,
  output logic [1:0]        o_occupancy
);

  localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              is_branch;
    logic              in_delay_slot;
    logic [4:0]        cause;
    logic              valid;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t w_in_entry;
  logic   last_br_q, last_br_d;
  logic   up_ready_q;
  logic   w_fire_in;
  logic   w_fire_out;
  logic [4:0] w_cause;

  assign w_fire_in  = i_up_valid & up_ready_q & ~i_flush;
  assign w_fire_out = main_q.valid & i_dn_ready;

  assign w_cause = i_up_bad_addr ? (i_up_dmem_we ? EXC_CAUSE_ADES : EXC_CAUSE_ADEL)
                                 : i_up_except_cause;

  always_comb begin
    w_in_entry               = '0;
    w_in_entry.data          = i_up_data;
    w_in_entry.ctrl          = i_up_ctrl;
    w_in_entry.pc            = i_up_pc;
    w_in_entry.instr         = i_up_instr;
    w_in_entry.is_branch     = i_up_is_branch;
    w_in_entry.in_delay_slot = last_br_q;
    w_in_entry.cause         = w_cause;
    w_in_entry.valid         = 1'b1;
  end

  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    last_br_d = last_br_q;
    if (i_flush) begin
      main_d.valid = 1'b0;
      main_d.ctrl  = CTRL_RST;
      skid_d.valid = 1'b0;
      last_br_d    = 1'b0;
    end else begin
      if (w_fire_in) begin
        last_br_d = i_up_is_branch;
      end
      if (!main_q.valid) begin
        if (w_fire_in) begin
          main_d = w_in_entry;
        end
      end else if (w_fire_out) begin
        if (skid_q.valid) begin
          main_d = skid_q;
          if (w_fire_in) begin
            skid_d = w_in_entry;
          end else begin
            skid_d.valid = 1'b0;
          end
        end else if (w_fire_in) begin
          main_d = w_in_entry;
        end else begin
          main_d.valid = 1'b0;
        end
      end else if (w_fire_in) begin
        // Ready is registered, so one beat can land after downstream stalls.
        skid_d = w_in_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_q      <= '0;
      main_q.ctrl <= CTRL_RST;
      skid_q      <= '0;
      skid_q.ctrl <= CTRL_RST;
      last_br_q   <= 1'b0;
      up_ready_q  <= 1'b0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      last_br_q   <= last_br_d;
      up_ready_q  <= ~skid_d.valid;
    end
  end

  assign o_up_ready         = up_ready_q;
  assign o_dn_valid         = main_q.valid;
  assign o_dn_data          = main_q.data;
  assign o_dn_ctrl          = main_q.valid ? main_q.ctrl : CTRL_RST;
  assign o_dn_pc            = main_q.pc;
  assign o_dn_instr         = main_q.instr;
  assign o_dn_is_branch     = main_q.valid & main_q.is_branch;
  assign o_dn_in_delay_slot = main_q.valid & main_q.in_delay_slot;
  assign o_dn_except_cause  = main_q.cause;
  assign o_occupancy        = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int              DATA_W   = 96;
  localparam int              CTRL_W   = 16;
  localparam logic [CTRL_W-1:0] CTRL_RST = 16'hDEAD;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_flush;
  logic              i_up_valid;
  logic              o_up_ready;
  logic [DATA_W-1:0] i_up_data;
  logic [CTRL_W-1:0] i_up_ctrl;
  logic [31:0]       i_up_pc;
  logic [31:0]       i_up_instr;
  logic              i_up_is_branch;
  logic              i_up_bad_addr;
  logic              i_up_dmem_we;
  logic [4:0]        i_up_except_cause;
  logic              o_dn_valid;
  logic              i_dn_ready;
  logic [DATA_W-1:0] o_dn_data;
  logic [CTRL_W-1:0] o_dn_ctrl;
  logic [31:0]       o_dn_pc;
  logic [31:0]       o_dn_instr;
  logic              o_dn_is_branch;
  logic              o_dn_in_delay_slot;
  logic [4:0]        o_dn_except_cause;
  logic [1:0]        o_occupancy;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .i_flush            (i_flush),
    .i_up_valid         (i_up_valid),
    .o_up_ready         (o_up_ready),
    .i_up_data          (i_up_data),
    .i_up_ctrl          (i_up_ctrl),
    .i_up_pc            (i_up_pc),
    .i_up_instr         (i_up_instr),
    .i_up_is_branch     (i_up_is_branch),
    .i_up_bad_addr      (i_up_bad_addr),
    .i_up_dmem_we       (i_up_dmem_we),
    .i_up_except_cause  (i_up_except_cause),
    .o_dn_valid         (o_dn_valid),
    .i_dn_ready         (i_dn_ready),
    .o_dn_data          (o_dn_data),
    .o_dn_ctrl          (o_dn_ctrl),
    .o_dn_pc            (o_dn_pc),
    .o_dn_instr         (o_dn_instr),
    .o_dn_is_branch     (o_dn_is_branch),
    .o_dn_in_delay_slot (o_dn_in_delay_slot),
    .o_dn_except_cause  (o_dn_except_cause),
    .o_occupancy        (o_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              is_br;
    logic              ds;
    logic [4:0]        cause;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic stream_phase = 1'b0;

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5A5A5A5A};
  endfunction
  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [31:0] pc);
    return pc[15:0] ^ 16'h0F0F;
  endfunction
  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic is_br, input logic bad,
                      input logic we, input logic [4:0] cin,
                      input logic exp_ds, input logic [4:0] exp_c);
    exp_t e;
    logic ok;
    i_up_valid        = 1'b1;
    i_up_pc           = pc;
    i_up_data         = mk_data(pc);
    i_up_ctrl         = mk_ctrl(pc);
    i_up_instr        = mk_instr(pc);
    i_up_is_branch    = is_br;
    i_up_bad_addr     = bad;
    i_up_dmem_we      = we;
    i_up_except_cause = cin;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (o_up_ready === 1'b1) begin
        e.pc = pc; e.instr = mk_instr(pc); e.ctrl = mk_ctrl(pc); e.data = mk_data(pc);
        e.is_br = is_br; e.ds = exp_ds; e.cause = exp_c;
        q.push_back(e);
        ok = 1'b1;
      end
      step();
    end
    i_up_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: pc 0x%0h never accepted", pc);
    end
  endtask

  // Scoreboard monitor: compares every consumed head against the queue.
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (o_dn_valid && i_dn_ready && !i_flush) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: pc 0x%0h emitted with empty scoreboard", o_dn_pc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (o_dn_pc !== e.pc || o_dn_instr !== e.instr || o_dn_ctrl !== e.ctrl ||
              o_dn_data !== e.data || o_dn_is_branch !== e.is_br ||
              o_dn_in_delay_slot !== e.ds || o_dn_except_cause !== e.cause) begin
            n_err++;
            $display("FAIL out_entry: got pc=%h ctrl=%h br=%b ds=%b cause=%0d data=%h expected pc=%h ctrl=%h br=%b ds=%b cause=%0d data=%h",
                     o_dn_pc, o_dn_ctrl, o_dn_is_branch, o_dn_in_delay_slot, o_dn_except_cause, o_dn_data,
                     e.pc, e.ctrl, e.is_br, e.ds, e.cause, e.data);
          end
        end
      end else if (!o_dn_valid) begin
        n_vec++;
        if (o_dn_ctrl !== CTRL_RST || o_dn_is_branch !== 1'b0 || o_dn_in_delay_slot !== 1'b0) begin
          n_err++;
          $display("FAIL bubble_fields: got ctrl=%h br=%b ds=%b expected ctrl=%h br=0 ds=0",
                   o_dn_ctrl, o_dn_is_branch, o_dn_in_delay_slot, CTRL_RST);
        end
      end
      if (stream_phase) begin
        n_vec++;
        if (o_occupancy > 2'd1) begin
          n_err++;
          $display("FAIL stream_occ: got %0d expected <= 1", o_occupancy);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0; i_flush = 1'b0; i_up_valid = 1'b1; i_dn_ready = 1'b1;
    i_up_data = '0; i_up_ctrl = '0; i_up_pc = 32'h0; i_up_instr = 32'h0;
    i_up_is_branch = 1'b0; i_up_bad_addr = 1'b0; i_up_dmem_we = 1'b0;
    i_up_except_cause = 5'd0;

    // Reset held two cycles with upstream valid.
    repeat (2) begin
      @(negedge clk);
      chk("rst_dn_valid", {31'd0, o_dn_valid}, 32'd0);
      chk("rst_dn_ctrl", {16'd0, o_dn_ctrl}, {16'd0, CTRL_RST});
      chk("rst_up_ready", {31'd0, o_up_ready}, 32'd0);
    end
    step();
    resetn = 1'b1;
    i_up_valid = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, o_up_ready}, 32'd1);
    chk("post_rst_occ", {30'd0, o_occupancy}, 32'd0);
    chk("post_rst_pc", o_dn_pc, 32'd0);
    chk("post_rst_cause", {27'd0, o_dn_except_cause}, 32'd0);
    mon_en = 1'b1;

    // Streaming 0x100..0x11C.
    stream_phase = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    stream_phase = 1'b0;
    step();

    // Backpressure: downstream stalls for 3 edges mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'h140 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_dn_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_before", {31'd0, o_up_ready}, 32'd1);
        chk("bp_occ_before", {30'd0, o_occupancy}, 32'd1);
        @(negedge clk);
        chk("bp_occ_full", {30'd0, o_occupancy}, 32'd2);
        chk("bp_ready_low", {31'd0, o_up_ready}, 32'd0);
        @(negedge clk);
        chk("bp_occ_hold", {30'd0, o_occupancy}, 32'd2);
        @(posedge clk);
        #1 i_dn_ready = 1'b1;
        @(negedge clk);
        chk("bp_occ_release", {30'd0, o_occupancy}, 32'd2);
        @(negedge clk);
        chk("bp_occ_drained", {30'd0, o_occupancy}, 32'd1);
        chk("bp_ready_back", {31'd0, o_up_ready}, 32'd1);
      end
    join
    repeat (2) step();

    // Cause merge.
    send(32'h180, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd5);
    send(32'h184, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd4);
    send(32'h188, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0, 5'd10);
    send(32'h18C, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0, 5'd4);
    send(32'h190, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 5'd3);

    // Delay slot across an idle gap.
    send(32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) step();
    send(32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
    send(32'h208, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) step();

    // Flush with two held entries (one a branch) plus an incoming valid.
    i_dn_ready = 1'b0;
    send(32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    send(32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("pre_flush_occ", {30'd0, o_occupancy}, 32'd2);
    i_up_valid = 1'b1;
    i_up_pc = 32'h308; i_up_ctrl = mk_ctrl(32'h308); i_up_is_branch = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_up_valid = 1'b0;
    q.delete();
    chk("flush_occ", {30'd0, o_occupancy}, 32'd0);
    chk("flush_ready", {31'd0, o_up_ready}, 32'd1);
    chk("flush_ctrl", {16'd0, o_dn_ctrl}, {16'd0, CTRL_RST});
    chk("flush_valid", {31'd0, o_dn_valid}, 32'd0);
    i_dn_ready = 1'b1;
    send(32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    send(32'h404, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    step();
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("final_occ", {30'd0, o_occupancy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the generalised successor to the fixed-field ID/EXE latch. It carries one instruction's payload between any two adjacent stages of the Yttrium core using a valid/ready handshake. A two-entry skid buffer lets upstream see a registered ready. The block also provides flush-to-bubble, reset-safe control fields, internal delay-slot tracking and address-error cause merging.

## Interface
Parameters:
- DATA_W, 96: width of the opaque datapath payload (operands, addresses, rdata).
- CTRL_W, 16: width of the control payload (write enables, selectors, ALU op).
- CTRL_RST, {CTRL_W{1'b0}}: control value that represents a bubble. Used on reset, flush and whenever the output is not valid.

Ports:
- Clock and reset: one clock. Reset is synchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- i_flush  in  1  discard all held and incoming entries this cycle.
- i_up_valid  in  1  upstream presents an instruction.
- o_up_ready  out  1  block can accept this cycle. Registered: equals !skid_valid, and is 0 while resetn=0.
- i_up_data  in  DATA_W  datapath payload.
- i_up_ctrl  in  CTRL_W  control payload.
- i_up_pc  in  32  instruction PC.
- i_up_instr  in  32  instruction word.
- i_up_is_branch  in  1  instruction is a branch or jump.
- i_up_bad_addr  in  1  data address misaligned.
- i_up_dmem_we  in  1  instruction is a store.
- i_up_except_cause  in  5  cause already raised upstream.
- o_dn_valid  out  1  head entry valid.
- i_dn_ready  in  1  downstream consumes the head this cycle.
- o_dn_data  out  DATA_W  head payload.
- o_dn_ctrl  out  CTRL_W  head control; equals CTRL_RST when o_dn_valid=0.
- o_dn_pc  out  32  head PC.
- o_dn_instr  out  32  head instruction word.
- o_dn_is_branch  out  1  head is branch; 0 when not valid.
- o_dn_in_delay_slot  out  1  head sits in a branch delay slot; 0 when not valid.
- o_dn_except_cause  out  5  head exception cause.
- o_occupancy  out  2  number of held entries: 0, 1 or 2.

## Operation
- Storage is two entries: main (drives the outputs) and skid. Each entry holds data, ctrl, pc, instr, is_branch, in_delay_slot, cause and a valid bit.
- fire_in = i_up_valid & o_up_ready & !i_flush.
- fire_out = o_dn_valid & i_dn_ready.
- Cause merge on accept: if i_up_bad_addr, the cause is EXC_CAUSE_ADES (5'd5) when i_up_dmem_we=1, else EXC_CAUSE_ADEL (5'd4). Otherwise the cause is i_up_except_cause. Constants come from Exception.v.
- Delay-slot tracking: internal flag last_br.
  - On fire_in, the accepted entry gets in_delay_slot = last_br, and last_br <= i_up_is_branch.
  - Instruction ordering is never changed, so the flag stays exact across stalls.
- Update rules, with i_flush=0:
  - Main empty and fire_in: main loads the input.
  - Main full, fire_out, skid valid: main <= skid; skid <= input if fire_in, else skid becomes empty.
  - Main full, fire_out, skid empty: main <= input if fire_in, else main becomes empty.
  - Main full, no fire_out, fire_in: skid <= input. This case is only reachable when skid is empty.
  - Otherwise: hold.
- Flush: both valid bits clear, main ctrl <= CTRL_RST, last_br <= 0, and any input this cycle is dropped. Flush takes priority over every fire.
- Reset: all valid bits 0, ctrl = CTRL_RST, data/pc/instr/cause = 0, last_br = 0. Reset takes priority over flush.
- After reset, every output is at its reset value: o_dn_valid=0, o_dn_ctrl=CTRL_RST, o_dn_data/pc/instr/cause=0, is_branch/in_delay_slot=0, o_occupancy=0, o_up_ready=0 during reset and 1 on the first cycle after.

## Timing
- Latency: input accepted at edge N is visible on the outputs after edge N, i.e. in cycle N+1.
- Throughput: one instruction per cycle while i_dn_ready=1.
- o_up_ready depends only on registered state, so there is no combinational path from i_dn_ready to o_up_ready.
- After i_dn_ready drops, upstream may still deliver one more instruction, which goes to skid. o_up_ready then falls on the next cycle.
- o_up_ready returns to 1 the cycle after skid drains.
- Simultaneous fire_in and fire_out with occupancy 1: occupancy stays 1 and main is replaced.
- Flush with occupancy 2: in the next cycle occupancy=0, o_up_ready=1 and o_dn_ctrl=CTRL_RST.

## Test plan
- Reset: hold resetn=0 for 2 cycles with i_up_valid=1 -> o_dn_valid=0, o_dn_ctrl=CTRL_RST, o_up_ready=0. After release, o_up_ready=1 and o_occupancy=0.
- Streaming: pcs 0x100..0x11C, valid every cycle, i_dn_ready=1 -> same pcs out in order, each one cycle later, no gaps, occupancy never exceeds 1.
- Backpressure: drop i_dn_ready for 3 cycles mid-stream -> exactly one extra entry captured (occupancy=2), o_up_ready=0 on the next cycle. After release, no entry is lost or duplicated.
- Delay slot: branch at 0x200 followed by 0x204, with a 2-cycle stall between them -> 0x204 exits with in_delay_slot=1, 0x208 exits with 0.
- Cause merge: bad_addr=1 with dmem_we=1 -> cause 5; bad_addr=1 with dmem_we=0 -> cause 4; bad_addr=0 with cause 5'd10 -> cause 10.
- Flush: occupancy 2 plus an incoming valid, assert i_flush -> next cycle occupancy=0, o_dn_ctrl=CTRL_RST. The next instruction after the flush has in_delay_slot=0 even if a branch was flushed.
